i2c_ctrl_fsm: RTL



---
 rtl/i2c_ctrl_fsm.sv | 97 +++++++++
 1 files changed

// File: rtl/i2c_ctrl_fsm.sv
// i2c_ctrl_fsm: key-triggered three-byte I2C write sequencer with SCL generation and ACK checking
module i2c_ctrl_fsm #(
    parameter int BIT_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key,
    input  logic [7:0]  addr_byte,
    input  logic [15:0] data_word,
    input  logic        sda_in,
    output logic [3:0]  CS,
    output logic [3:0]  NS,
    output logic        tx_bit,
    output logic [2:0]  bit_idx,
    output logic        i2c_sclk,
    output logic        busy,
    output logic        done,
    output logic        ack_err
);
    localparam int PW = $clog2(BIT_CYCLES);
    typedef enum logic [3:0] {
        S_WAIT  = 4'd0,
        S_START = 4'd1,
        S_ADDR  = 4'd2,
        S_ACK1  = 4'd3,
        S_DATA1 = 4'd4,
        S_ACK2  = 4'd5,
        S_DATA2 = 4'd6,
        S_ACK3  = 4'd7,
        S_STOP  = 4'd8
    } state_t;
    state_t        state, next;
    logic          k1, k2, k3;
    logic [PW-1:0] ph;
    logic [23:0]   sr;
    logic          ack_bit;
    logic          start_req, bit_end, is_tx, is_ack;
    assign start_req = ~k2 & k3;
    assign bit_end   = ph == PW'(BIT_CYCLES - 1);
    assign is_tx     = state inside {S_ADDR, S_DATA1, S_DATA2};
    assign is_ack    = state inside {S_ACK1, S_ACK2, S_ACK3};
    assign CS        = state;
    assign NS        = next;
    assign busy      = state != S_WAIT;
    assign tx_bit    = is_tx ? sr[23] : 1'b1;
    assign i2c_sclk  = (state == S_WAIT || state == S_START) ? 1'b1 : (ph >= PW'(BIT_CYCLES / 2));
    // next-state decode; a NACK captured in any Ack slot diverts straight to Stop
    always_comb begin
        next = S_WAIT;
        case (state)
            S_WAIT:  next = start_req ? S_START : S_WAIT;
            S_START: next = bit_end ? S_ADDR : S_START;
            S_ADDR:  next = (bit_end && bit_idx == 3'd0) ? S_ACK1 : S_ADDR;
            S_ACK1:  next = bit_end ? (ack_bit ? S_STOP : S_DATA1) : S_ACK1;
            S_DATA1: next = (bit_end && bit_idx == 3'd0) ? S_ACK2 : S_DATA1;
            S_ACK2:  next = bit_end ? (ack_bit ? S_STOP : S_DATA2) : S_ACK2;
            S_DATA2: next = (bit_end && bit_idx == 3'd0) ? S_ACK3 : S_DATA2;
            S_ACK3:  next = bit_end ? S_STOP : S_ACK3;
            S_STOP:  next = bit_end ? S_WAIT : S_STOP;
            default: next = S_WAIT;
        endcase
    end
    // key synchronizer, state register, bit timing, shift register and ACK bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k1      <= 1'b1;
            k2      <= 1'b1;
            k3      <= 1'b1;
            state   <= S_WAIT;
            ph      <= '0;
            bit_idx <= 3'd7;
            sr      <= '0;
            ack_bit <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            k1    <= key;
            k2    <= k1;
            k3    <= k2;
            state <= next;
            done  <= state == S_STOP && bit_end;
            ph    <= (state == S_WAIT || bit_end) ? '0 : ph + PW'(1);
            if (state == S_WAIT && start_req) begin
                sr      <= {addr_byte, data_word};
                ack_err <= 1'b0;
            end
            if (is_tx && bit_end) begin
                sr      <= {sr[22:0], 1'b0};
                bit_idx <= bit_idx - 3'd1;
            end
            if (is_ack && ph == PW'(3 * BIT_CYCLES / 4))
                ack_bit <= sda_in;
            if (is_ack && bit_end && ack_bit)
                ack_err <= 1'b1;
        end
    end
endmodule
